instr_sequencer: RTL

Fetch/execute sequencer for the 4-bit micro datapath. It steps a program counter through a 16-word instruction memory, latches each 8-bit instruction, and presents its opcode to the instruction decoder. It generates the four-phase timing (T0..T3), including the single-cycle T2 execute strobe that qualifies every register enable. It supports free-run, single-step, restart and halt-at-end-of-program.

---
 rtl/instr_sequencer_pkg.sv | 35 +++
 rtl/instr_sequencer_phase_gen.sv | 87 ++++++++
 rtl/instr_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared types and constants for the fetch/execute sequencer.
//               Holds the sequencer state encoding, the opcode field
//               position within the instruction word and the phase numbering.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

   // Sequencer states. The state register drives every timing output
   // directly, so these codes are fixed.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_T0     = 3'd1,
      ST_T1     = 3'd2,
      ST_T2     = 3'd3,
      ST_T3     = 3'd4,
      ST_HALTED = 3'd5
   } seq_state_e;

   // Opcode field positions in an 8-bit instruction word. The opcode is
   // always the top OPCODE_W bits, whatever the word width.
   localparam int OPCODE_MSB = 7;
   localparam int OPCODE_LSB = 4;
   localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

   // Values reported on the phase output.
   localparam logic [1:0] PHASE_T0 = 2'd0;
   localparam logic [1:0] PHASE_T1 = 2'd1;
   localparam logic [1:0] PHASE_T2 = 2'd2;
   localparam logic [1:0] PHASE_T3 = 2'd3;

endpackage : instr_sequencer_pkg
`default_nettype wire

// File: rtl/instr_sequencer_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_phase_gen
// Description : Four-phase state machine of the instruction sequencer,
//               including the step rising-edge detector and the
//               single-step mode flag.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               run      - free-run level
//               step     - single-step request (edge detected here)
//               restart  - synchronous return to IDLE
//               wrapped  - last fetched address was the final one
//               state    - current sequencer state
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer_phase_gen
   import instr_sequencer_pkg::*;
#(
   parameter int WRAP = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       step,
   input  logic       restart,
   input  logic       wrapped,
   output seq_state_e state
);

   seq_state_e state_q, state_d;
   logic       step_d_q, step_d_d;
   logic       single_mode_q, single_mode_d;
   logic       step_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         step_d_q      <= 1'b0;
         single_mode_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_d_q      <= step_d_d;
         single_mode_q <= single_mode_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      single_mode_d = single_mode_q;
      step_d_d      = step;
      step_rise     = step & ~step_d_q;

      case (state_q)
         ST_IDLE: begin
            if (restart)        state_d = ST_IDLE;
            else if (run)       state_d = ST_T0;
            else if (step_rise) state_d = ST_T0;
         end
         ST_T0:   state_d = restart ? ST_IDLE : ST_T1;
         ST_T1:   state_d = restart ? ST_IDLE : ST_T2;
         ST_T2:   state_d = restart ? ST_IDLE : ST_T3;
         ST_T3: begin
            if (restart)                     state_d = ST_IDLE;
            else if (wrapped && (WRAP == 0)) state_d = ST_HALTED;
            else if (run && !single_mode_q)  state_d = ST_T0;
            else                             state_d = ST_IDLE;
         end
         ST_HALTED: begin
            if (restart) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // The flag belongs to one stepped instruction: it is dropped whenever
      // the machine (re)enters IDLE, and armed only when a step edge, not
      // run, launched the instruction.
      if (state_d == ST_IDLE) begin
         single_mode_d = 1'b0;
      end else if ((state_q == ST_IDLE) && (state_d == ST_T0)) begin
         single_mode_d = ~run;
      end
   end

   assign state = state_q;

endmodule : instr_sequencer_phase_gen
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/execute sequencer. Steps a PC through the instruction
//               memory, latches each instruction and generates the
//               T0..T3 timing with a single-cycle T2 execute strobe.
// Ports       : clk, rst_n       - clock, async active-low reset
//               run, step        - free-run level / single-step request
//               restart          - synchronous PC clear and return to IDLE
//               mem_addr         - instruction address (PC register)
//               mem_data         - instruction read data
//               opcode, operand  - latched instruction fields
//               t2, phase        - execute strobe, current phase
//               busy, halted     - executing / stopped at end of program
//               instr_done       - one-cycle pulse in T3
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int PC_WIDTH    = 4,
   parameter int INSTR_WIDTH = 8,
   parameter int WRAP        = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   input  logic                         step,
   input  logic                         restart,
   output logic [PC_WIDTH-1:0]          mem_addr,
   input  logic [INSTR_WIDTH-1:0]       mem_data,
   output logic [OPCODE_W-1:0]          opcode,
   output logic [INSTR_WIDTH-OPCODE_W-1:0] operand,
   output logic                         t2,
   output logic [1:0]                   phase,
   output logic                         busy,
   output logic                         halted,
   output logic                         instr_done
);

   seq_state_e             state;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   logic                   wrapped_q, wrapped_d;

   instr_sequencer_phase_gen #(
      .WRAP (WRAP)
   ) u_phase_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .step    (step),
      .restart (restart),
      .wrapped (wrapped_q),
      .state   (state)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         ir_q      <= '0;
         wrapped_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         wrapped_q <= wrapped_d;
      end
   end

   // Restart clears the PC in every state. A restart landing in T1 also
   // suppresses the fetch, so the previous instruction stays in IR.
   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      wrapped_d = wrapped_q;
      if (restart) begin
         pc_d = '0;
      end else if (state == ST_T1) begin
         ir_d      = mem_data;
         pc_d      = pc_q + PC_WIDTH'(1);
         wrapped_d = &pc_q;
      end
   end

   // Timing outputs decode from the state register alone.
   always_comb begin
      t2         = 1'b0;
      busy       = 1'b0;
      halted     = 1'b0;
      instr_done = 1'b0;
      phase      = PHASE_T0;
      case (state)
         ST_T0: begin
            busy  = 1'b1;
            phase = PHASE_T0;
         end
         ST_T1: begin
            busy  = 1'b1;
            phase = PHASE_T1;
         end
         ST_T2: begin
            busy  = 1'b1;
            t2    = 1'b1;
            phase = PHASE_T2;
         end
         ST_T3: begin
            busy       = 1'b1;
            instr_done = 1'b1;
            phase      = PHASE_T3;
         end
         ST_HALTED: halted = 1'b1;
         default: ;
      endcase
   end

   assign mem_addr = pc_q;
   assign opcode   = ir_q[INSTR_WIDTH-1 -: OPCODE_W];
   assign operand  = ir_q[INSTR_WIDTH-OPCODE_W-1:0];

endmodule : instr_sequencer
`default_nettype wire
